// File: rtl/fp64_pkg.sv
// Shared widths and FSM state type for the double-precision adder datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp64_pkg;

    localparam int EXP_W    = 11;
    localparam int FRAC_W   = 52;
    localparam int MANT_W   = 57;   // carry, hidden, 52 fraction, guard, round, sticky
    localparam int EXP_BIAS = 1023;
    localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/round_rne64.sv
// Mantissa rounder: round-to-nearest-even on G/R/S, or pass-through truncation.
// Latency: combinational.
// Backpressure: none; pure function of its input.
// Ports: mant (57-bit raw mantissa) -> mant_rnd (rounded mantissa), carry (increment reached bit 56).
// Build option: define ROUNDING_EN for round-to-nearest-even; otherwise truncate.
module round_rne64
    import fp64_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    output logic [MANT_W-1:0] mant_rnd,
    output logic              carry
);

`ifdef ROUNDING_EN
    // Round up when strictly above half, or exactly half with an odd LSB (bit 3).
    logic inc;
    assign inc      = mant[2] & (mant[1] | mant[0] | mant[3]);
    assign mant_rnd = mant + {{(MANT_W-4){1'b0}}, inc, 3'b000};
`else
    // Truncation: G/R/S are simply dropped at packing time.
    assign mant_rnd = mant;
`endif

    assign carry = mant_rnd[MANT_W-1];

endmodule

// File: rtl/renormalise64.sv
// Iterative post-add renormaliser/packer producing an IEEE-754 double from a raw sum.
// Latency: done rises 2+k cycles after load (k = shifts, 1 for carry, 0 normal/zero), max 57.
// Backpressure: none; en low freezes all state, a new load aborts and restarts.
// Ports: clk, rst_n (sync, active-low), en, load, sS/Sm/eS inputs; result, done, busy,
//        overflow, underflow, zero outputs (all registered).
// Build option: ROUNDING_EN selects round-to-nearest-even in round_rne64 (else truncate).
module renormalise64
    import fp64_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       load,
    input  logic                       sS,
    input  logic [MANT_W-1:0]          Sm,
    input  logic [EXP_W-1:0]           eS,
    output logic [EXP_W+FRAC_W:0]      result,
    output logic                       done,
    output logic                       busy,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       zero
);

    state_t            state;
    logic              sign_q;
    logic [MANT_W-1:0] mant_q;
    logic [EXP_W:0]    exp_q;     // one extra bit so 2046+1 is visible
    logic              zero_q;
    logic              unf_q;

    logic [MANT_W-1:0] mant_rnd;
    logic              rnd_carry;

    round_rne64 u_round (
        .mant     (mant_q),
        .mant_rnd (mant_rnd),
        .carry    (rnd_carry)
    );

    // Post-round renormalisation: a carry out of the increment costs one right shift.
    logic [MANT_W-1:0]        mant_fin;
    logic [EXP_W:0]           exp_fin;
    logic [EXP_W+FRAC_W:0]    pack;
    logic                     ovf_pack;
    logic                     unused_bits;

    always_comb begin
        mant_fin = mant_rnd;
        exp_fin  = exp_q;
        if (rnd_carry) begin
            mant_fin = {1'b0, mant_rnd[MANT_W-1:1]};
            exp_fin  = exp_q + 12'd1;
        end
    end

    // Overflow is judged on the 12-bit exponent before truncation to the field width.
    always_comb begin
        pack     = {sign_q, exp_fin[EXP_W-1:0], mant_fin[54:3]};
        ovf_pack = 1'b0;
        if (exp_fin >= 12'd2047) begin
            pack     = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            ovf_pack = 1'b1;
        end else if (zero_q) begin
            pack = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
        end else if (unf_q) begin
            pack = {sign_q, {EXP_W{1'b0}}, mant_fin[54:3]};
        end
    end

    // Carry/hidden and G/R/S are consumed above; they never reach the packed word.
    assign unused_bits = ^{mant_fin[56:55], mant_fin[2:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            mant_q    <= '0;
            exp_q     <= '0;
            zero_q    <= 1'b0;
            unf_q     <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            if (load) begin
                // Accepted in any state; an in-flight conversion is simply dropped.
                state     <= NORM;
                sign_q    <= sS;
                mant_q    <= Sm;
                exp_q     <= {1'b0, eS};
                zero_q    <= 1'b0;
                unf_q     <= 1'b0;
                done      <= 1'b0;
                busy      <= 1'b1;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                zero      <= 1'b0;
            end else begin
                case (state)
                    NORM: begin
                        if (mant_q == '0) begin
                            zero_q <= 1'b1;
                            state  <= ROUND;
                        end else if (mant_q[56]) begin
                            // Right shift folds the dropped bit into sticky. The hidden bit
                            // is now set, so the next NORM cycle moves on to ROUND; this
                            // gives the carry case its one cycle of extra latency.
                            mant_q <= {1'b0, mant_q[56:2], mant_q[1] | mant_q[0]};
                            exp_q  <= exp_q + 12'd1;
                        end else if (!mant_q[55] && exp_q > 12'd1) begin
                            mant_q <= {mant_q[55:0], 1'b0};
                            exp_q  <= exp_q - 12'd1;
                        end else if (!mant_q[55]) begin
                            unf_q <= 1'b1;
                            state <= ROUND;
                        end else begin
                            state <= ROUND;
                        end
                    end
                    ROUND: begin
                        mant_q    <= mant_fin;
                        exp_q     <= exp_fin;
                        result    <= pack;
                        overflow  <= ovf_pack;
                        underflow <= unf_q;
                        zero      <= zero_q;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_renormalise64.sv
// Scoreboard bench for renormalise64: directed cases plus random sums against a reference model.
// Latency: checks done-rise cycle relative to the load edge.
// Backpressure: exercises en-low stretching, ignored loads, abort/restart and reset mid-run.
module tb_renormalise64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic        sS;
    logic [56:0] Sm;
    logic [10:0] eS;
    logic [63:0] result;
    logic        done;
    logic        busy;
    logic        overflow;
    logic        underflow;
    logic        zero;

    always #5 clk = ~clk;

    renormalise64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .sS        (sS),
        .Sm        (Sm),
        .eS        (eS),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        ovf;
        logic        unf;
        logic        zro;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [63:0] res, input logic ovf,
                                input logic unf, input logic zro, input int lat);
        exp_t x;
        x.name = nm; x.res = res; x.ovf = ovf; x.unf = unf; x.zro = zro;
        x.lat = lat; x.e0 = 0;
        return x;
    endfunction

    // Reference: locate the leading one, shift in one step (bounded by the exponent floor),
    // round on the resulting G/R/S, then pack.
    function automatic exp_t model(input string nm, input logic s, input logic [56:0] m_in,
                                   input logic [10:0] e_in);
        exp_t            x;
        logic [63:0]     m;
        int              e;
        int              k;
        int              p;
        int              shifts;
        x = mk(nm, 64'h0, 1'b0, 1'b0, 1'b0, 2);
        m = 64'(m_in);
        e = int'(e_in);
        k = 0;
        if (m == 64'h0) begin
            x.zro = 1'b1;
            x.res = {s, 63'h0};
            return x;
        end
        if (m[56]) begin
            m = (m >> 1) | (m & 64'h1);
            e = e + 1;
            k = 1;
        end else begin
            p = 55;
            while (!m[p]) p--;
            shifts = 55 - p;
            if (shifts <= e - 1) begin
                m = m << shifts;
                e = e - shifts;
                k = shifts;
            end else begin
                m = m << (e - 1);
                k = e - 1;
                e = 1;
                x.unf = 1'b1;
            end
        end
`ifdef ROUNDING_EN
        if (m[2] && (m[1] || m[0] || m[3])) begin
            m = m + 64'd8;
            if (m[56]) begin
                m = m >> 1;
                e = e + 1;
            end
        end
`endif
        x.lat = 2 + k;
        if (e >= 2047) begin
            x.ovf = 1'b1;
            x.res = {s, 11'h7FF, 52'h0};
        end else if (x.unf) begin
            x.res = {s, 11'h000, m[54:3]};
        end else begin
            x.res = {s, e[10:0], m[54:3]};
        end
        return x;
    endfunction

    // Called at a negedge; load is seen at the next posedge (E0). A new load aborts
    // whatever was pending, so its expectation is discarded.
    task automatic issue(input exp_t xin, input logic s, input logic [56:0] m,
                         input logic [10:0] e, input int extra);
        exp_t x;
        x     = xin;
        sS    = s;
        Sm    = m;
        eS    = e;
        load  = 1'b1;
        x.e0  = cyc + 1;
        x.lat = x.lat + extra;
        sb.delete();
        sb.push_back(x);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: done not seen within 200 cycles, expected %h", nm, sb[0].res);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " result"}, result, 64'h0);
        check({nm, " ctl"}, 64'({done, busy, overflow, underflow, zero}), 64'h0);
    endtask

    // Monitor: every rising edge of done retires one scoreboard entry.
    initial begin : monitor
        logic done_prev;
        exp_t x;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done rose with result %h, expected no done", result);
                end else begin
                    x = sb.pop_front();
                    check({x.name, " result"}, result, x.res);
                    check({x.name, " flags ovf/unf/zero"}, 64'({overflow, underflow, zero}),
                          64'({x.ovf, x.unf, x.zro}));
                    check({x.name, " latency"}, 64'(cyc - x.e0), 64'(x.lat));
                    check({x.name, " busy"}, 64'(busy), 64'h0);
                end
            end
            done_prev = done;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [56:0] m;
        rst_n = 1'b0;
        en    = 1'b1;
        load  = 1'b0;
        sS    = 1'b0;
        Sm    = '0;
        eS    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        m = 57'd1 << 55;
        issue(mk("normal", 64'h3FF0000000000000, 0, 0, 0, 2), 1'b0, m, 11'd1023, 0);
        wait_drain("normal");

        m = 57'd3 << 55;
        issue(mk("carry", 64'h4008000000000000, 0, 0, 0, 3), 1'b0, m, 11'd1023, 0);
        wait_drain("carry");

        m = 57'd1 << 52;
        issue(mk("left_shift", 64'h3FC0000000000000, 0, 0, 0, 5), 1'b0, m, 11'd1023, 0);
        check("busy_mid", 64'({busy, done}), 64'b10);
        wait_drain("left_shift");

        // Two shifts bring the leading one to bit 42 at exp 1; fraction bit 39 remains.
        m = 57'd1 << 40;
        issue(mk("underflow", 64'h0000008000000000, 0, 1, 0, 4), 1'b0, m, 11'd3, 0);
        wait_drain("underflow");

        issue(mk("zero", 64'h8000000000000000, 0, 0, 1, 2), 1'b1, 57'd0, 11'd500, 0);
        wait_drain("zero");

        // A load with en low must be ignored: the previous result stays presented.
        en   = 1'b0;
        load = 1'b1;
        Sm   = 57'd3 << 55;
        eS   = 11'd5;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        repeat (2) @(negedge clk);
        check("ignored_load result", result, 64'h8000000000000000);
        check("ignored_load done/zero", 64'({done, zero}), 64'b11);

        m = {2'b01, {52{1'b1}}, 3'b100};
`ifdef ROUNDING_EN
        issue(mk("rounding", 64'h4000000000000000, 0, 0, 0, 2), 1'b0, m, 11'd1023, 0);
`else
        issue(mk("rounding", 64'h3FFFFFFFFFFFFFFF, 0, 0, 0, 2), 1'b0, m, 11'd1023, 0);
`endif
        wait_drain("rounding");

        // en low for three cycles stretches the carry case from 3 to 6.
        m = 57'd3 << 55;
        issue(mk("en_stretch", 64'h4008000000000000, 0, 0, 0, 3), 1'b0, m, 11'd1023, 3);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_drain("en_stretch");

        m = 57'd3 << 55;
        issue(mk("overflow", 64'h7FF0000000000000, 1, 0, 0, 3), 1'b0, m, 11'd2046, 0);
        wait_drain("overflow");

        // Restart one cycle into an overflow conversion.
        m = 57'd3 << 55;
        issue(mk("overflow_aborted", 64'h7FF0000000000000, 1, 0, 0, 3), 1'b1, m, 11'd2046, 0);
        m = 57'd1 << 52;
        issue(mk("restart", 64'h3FC0000000000000, 0, 0, 0, 5), 1'b0, m, 11'd1023, 0);
        wait_drain("restart");

        // Reset mid-conversion discards it; no done may follow.
        m = 57'd1 << 20;
        issue(mk("reset_victim", 64'h0, 0, 0, 0, 37), 1'b0, m, 11'd1023, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        check_all_zero("reset_mid");
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check_all_zero("post_reset_idle");

        for (int i = 0; i < 60; i++) begin
            logic [63:0] r;
            logic [56:0] mr;
            logic [10:0] er;
            logic        sr;
            int          p;
            r  = {$urandom, $urandom};
            sr = r[63];
            case ($urandom_range(0, 9))
                0:       mr = 57'd0;
                1, 2:    mr = r[56:0] | (57'd1 << 56);
                default: begin
                    p  = $urandom_range(0, 55);
                    mr = (r[56:0] & ((57'd1 << p) - 57'd1)) | (57'd1 << p);
                end
            endcase
            case ($urandom_range(0, 5))
                0:       er = 11'd1;
                1:       er = 11'd2046;
                2:       er = 11'($urandom_range(2, 56));
                default: er = 11'($urandom_range(1, 2046));
            endcase
            issue(model("random", sr, mr, er), sr, mr, er, 0);
            wait_drain("random");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
